// File: rtl/gpio_port.sv
// Bus-mapped GPIO port: per-pin direction, synchronised inputs, atomic set/reset
// writes and per-pin rising/falling edge interrupts with write-1-to-clear flags.
module gpio_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    inout  wire  [WIDTH-1:0] ioport,
    output logic        irq
);

    localparam logic [2:0] ADDR_MODER = 3'd0;
    localparam logic [2:0] ADDR_IDR   = 3'd1;
    localparam logic [2:0] ADDR_ODR   = 3'd2;
    localparam logic [2:0] ADDR_BSRR  = 3'd3;
    localparam logic [2:0] ADDR_RISE  = 3'd4;
    localparam logic [2:0] ADDR_FALL  = 3'd5;
    localparam logic [2:0] ADDR_ISR   = 3'd6;

    logic [WIDTH-1:0] r_moder;
    logic [WIDTH-1:0] r_odr;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_isr;
    logic [WIDTH-1:0] r_prev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic             r_irq;

    logic [2:0]       w_sel;
    logic             w_wr_en;
    logic             w_wr_moder;
    logic             w_wr_odr;
    logic             w_wr_bsrr;
    logic             w_wr_rise;
    logic             w_wr_fall;
    logic             w_wr_isr;
    logic [WIDTH-1:0] w_idr;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_odr_next;
    logic [WIDTH-1:0] w_isr_next;
    logic             w_unused;

    // Only addr[4:2] and the low/upper-half data lanes matter to this block.
    assign w_unused = ^{addr, wdata};

    assign w_sel      = addr[4:2];
    assign w_wr_en    = cs & wr;
    assign w_wr_moder = w_wr_en && (w_sel == ADDR_MODER);
    assign w_wr_odr   = w_wr_en && (w_sel == ADDR_ODR);
    assign w_wr_bsrr  = w_wr_en && (w_sel == ADDR_BSRR);
    assign w_wr_rise  = w_wr_en && (w_sel == ADDR_RISE);
    assign w_wr_fall  = w_wr_en && (w_sel == ADDR_FALL);
    assign w_wr_isr   = w_wr_en && (w_sel == ADDR_ISR);

    assign w_idr = r_sync[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            assign ioport[gi] = r_moder[gi] ? r_odr[gi] : 1'bz;

            assign w_rise[gi] = w_idr[gi] & ~r_prev[gi];
            assign w_fall[gi] = ~w_idr[gi] & r_prev[gi];
            assign w_set[gi]  = (w_rise[gi] & r_rise_en[gi]) | (w_fall[gi] & r_fall_en[gi]);

            // A new edge outranks a simultaneous write-1-to-clear.
            assign w_isr_next[gi] = w_set[gi] | (r_isr[gi] & ~(w_wr_isr & wdata[gi]));
        end
    endgenerate

    always_comb begin
        w_odr_next = r_odr;
        if (w_wr_odr) begin
            w_odr_next = wdata[WIDTH-1:0];
        end else if (w_wr_bsrr) begin
            // Clear first, then set, so set wins when both bits are 1.
            w_odr_next = (r_odr & ~wdata[16 +: WIDTH]) | wdata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= ioport;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_moder   <= '0;
            r_odr     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_isr     <= '0;
            r_prev    <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_moder) r_moder   <= wdata[WIDTH-1:0];
            if (w_wr_rise)  r_rise_en <= wdata[WIDTH-1:0];
            if (w_wr_fall)  r_fall_en <= wdata[WIDTH-1:0];
            r_odr  <= w_odr_next;
            r_isr  <= w_isr_next;
            r_prev <= w_idr;
            r_irq  <= |r_isr;
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = '0;
        case (w_sel)
            ADDR_MODER: rdata[WIDTH-1:0] = r_moder;
            ADDR_IDR:   rdata[WIDTH-1:0] = w_idr;
            ADDR_ODR:   rdata[WIDTH-1:0] = r_odr;
            ADDR_RISE:  rdata[WIDTH-1:0] = r_rise_en;
            ADDR_FALL:  rdata[WIDTH-1:0] = r_fall_en;
            ADDR_ISR:   rdata[WIDTH-1:0] = r_isr;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_port.sv
// Scoreboard bench for gpio_port: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    wire  [7:0]  pins;
    logic [7:0]  tb_oe;
    logic [7:0]  tb_drv;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp_val;
    } sb_item_t;
    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_drv
            assign pins[gi] = tb_oe[gi] ? tb_drv[gi] : 1'bz;
        end
    endgenerate

    gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ioport (pins),
        .irq    (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_chk++;
        if (obs !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp_val);
        sb_item_t e;
        e.tag     = tag;
        e.exp_val = exp_val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_item_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty: got %h expected a queued entry", obs);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.exp_val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [31:0] data);
        addr  = {27'd0, idx, 2'b00};
        wdata = data;
        cs    = 1'b1;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        cs    = 1'b0;
        wr    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [2:0] idx, input string tag, input logic [31:0] exp_val);
        sb_push(tag, exp_val);
        addr = {27'd0, idx, 2'b00};
        cs   = 1'b1;
        wr   = 1'b0;
        #1;
        sb_pop(rdata);
        cs   = 1'b0;
    endtask

    task automatic pin_chk(input string tag, input logic [7:0] exp_val);
        sb_push(tag, {24'd0, exp_val});
        sb_pop({24'd0, pins});
    endtask

    task automatic irq_chk(input string tag, input logic exp_val);
        sb_push(tag, {31'd0, exp_val});
        sb_pop({31'd0, irq});
    endtask

    // High-Z pins read as Z in a four-state simulator and as 0 in a two-state one.
    task automatic z_chk(input string tag);
        sb_push(tag, 32'd1);
        sb_pop({31'd0, ((pins === 8'hzz) || (pins === 8'h00))});
    endtask

    initial begin
        reset  = 1'b1;
        cs     = 1'b0;
        wr     = 1'b0;
        addr   = '0;
        wdata  = '0;
        tb_oe  = 8'h00;
        tb_drv = 8'h00;
        tick(2);
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            rd(i[2:0], $sformatf("rst_rd%0d", i), 32'd0);
            if (i == 3) tick(1);
        end
        irq_chk("rst_irq", 1'b0);
        z_chk("rst_pins_z");

        // Output drive and atomic set/reset
        wr_reg(3'd0, 32'h0000_00FF);
        wr_reg(3'd2, 32'h0000_00A5);
        pin_chk("odr_pins", 8'hA5);
        wr_reg(3'd3, 32'h0003_0005);
        rd(3'd2, "bsrr_set_wins", 32'h0000_00A5);
        rd(3'd3, "bsrr_reads0", 32'd0);
        wr_reg(3'd3, 32'h00A0_0002);
        rd(3'd2, "bsrr_mix", 32'h0000_0007);
        pin_chk("bsrr_pins", 8'h07);
        wr_reg(3'd1, 32'h0000_00FF);
        wr_reg(3'd7, 32'h0000_00FF);
        tick(2);
        rd(3'd1, "idr_readback", 32'h0000_0007);
        rd(3'd7, "reserved0", 32'd0);
        rd(3'd0, "moder_kept", 32'h0000_00FF);

        // Rising edge on input pin 3
        wr_reg(3'd0, 32'd0);
        tb_drv = 8'h00;
        tb_oe  = 8'hFF;
        tick(4);
        wr_reg(3'd4, 32'h0000_0008);
        tb_drv[3] = 1'b1;
        tick(1);
        rd(3'd1, "idr_lat1", 32'd0);
        tick(1);
        rd(3'd1, "idr_lat2", 32'h0000_0008);
        rd(3'd6, "isr_lat2", 32'd0);
        tick(1);
        rd(3'd6, "isr_lat3", 32'h0000_0008);
        irq_chk("irq_lat3", 1'b0);
        tick(1);
        irq_chk("irq_lat4", 1'b1);

        // W1C and irq drop
        wr_reg(3'd6, 32'h0000_00FF);
        rd(3'd6, "w1c_all", 32'd0);
        irq_chk("irq_hold", 1'b1);
        tick(1);
        irq_chk("irq_drop", 1'b0);

        // Falling edge on pin 0
        wr_reg(3'd5, 32'h0000_0001);
        tb_drv[0] = 1'b1;
        tick(4);
        rd(3'd6, "rise0_masked", 32'd0);
        tb_drv[0] = 1'b0;
        tick(3);
        rd(3'd6, "fall0_set", 32'h0000_0001);
        tick(1);
        irq_chk("fall0_irq", 1'b1);
        wr_reg(3'd6, 32'd0);
        rd(3'd6, "w1c_zero", 32'h0000_0001);
        wr_reg(3'd6, 32'h0000_0001);
        rd(3'd6, "w1c_bit0", 32'd0);
        tick(1);
        irq_chk("fall0_irq_drop", 1'b0);

        // Edge coincident with W1C on pin 5
        wr_reg(3'd4, 32'h0000_0028);
        tb_drv[5] = 1'b1;
        tick(3);
        rd(3'd6, "rise5_first", 32'h0000_0020);
        tb_drv[5] = 1'b0;
        tick(3);
        rd(3'd6, "rise5_hold", 32'h0000_0020);
        tb_drv[5] = 1'b1;
        tick(2);
        wr_reg(3'd6, 32'h0000_0020);
        rd(3'd6, "set_beats_w1c", 32'h0000_0020);
        tick(1);
        rd(3'd6, "set_beats_w1c2", 32'h0000_0020);
        irq_chk("set_beats_irq", 1'b1);

        // Output readback raises edges, then reset mid-operation
        tb_drv = 8'h00;
        tick(4);
        tb_oe = 8'h00;
        wr_reg(3'd2, 32'd0);
        wr_reg(3'd0, 32'h0000_00FF);
        wr_reg(3'd2, 32'h0000_003C);
        pin_chk("out_pins", 8'h3C);
        tick(4);
        rd(3'd6, "out_edge_isr", 32'h0000_0028);
        rd(3'd1, "out_idr", 32'h0000_003C);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        irq_chk("rst2_irq", 1'b0);
        z_chk("rst2_pins_z");
        for (int i = 0; i < 8; i++) begin
            rd(i[2:0], $sformatf("rst2_rd%0d", i), 32'd0);
            if (i == 3) tick(1);
        end

        if (sb_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised general-purpose I/O port for the CPU peripheral bus. It provides `WIDTH` bidirectional pins with per-pin direction, a synchronised input register and an output data register. It adds two things the basic GPIO lacks: atomic bit set/reset writes and per-pin rising/falling edge interrupts with write-1-to-clear pending flags. It sits behind the address decoder, on the same `cs`/`wr`/`addr`/`wdata`/`rdata` bus as the other peripherals, and drives one `irq` line to the interrupt controller.

## Interface
- `WIDTH`, 8: number of pins; legal range 1..16.
- `SYNC_STAGES`, 2: input synchroniser depth; legal range 2..3.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cs`  in  1  peripheral select from the address decoder.
- `wr`  in  1  write strobe; a write occurs only when `cs & wr` is 1.
- `addr`  in  32  byte address; only `addr[4:2]` is decoded.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational from `addr[4:2]`; unused upper bits read 0.
- `ioport`  inout  WIDTH  pins; bit i is driven with `ODR[i]` when `MODER[i]`=1, otherwise it is high-Z.
- `irq`  out  1  registered; equals `|(ISR)`.

## Operation
- Register map, indexed by `addr[4:2]`. Only bits `[WIDTH-1:0]` are implemented unless stated otherwise.
  - 0 `MODER`: R/W; 1 = output.
  - 1 `IDR`: RO; synchronised pin levels; writes are ignored.
  - 2 `ODR`: R/W; output data.
  - 3 `BSRR`: WO, reads 0. A 1 in `wdata[i]` sets `ODR[i]`; a 1 in `wdata[16+i]` clears `ODR[i]`. If both set and clear are 1 for the same bit, set wins.
  - 4 `RISE`: R/W; rising-edge interrupt enable.
  - 5 `FALL`: R/W; falling-edge interrupt enable.
  - 6 `ISR`: pending flags; writing 1 to a bit clears it, writing 0 has no effect.
  - 7: reserved; reads 0, writes ignored.
- A write to any register other than the addressed one leaves that register unchanged. Registers hold their value when there is no write.
- Input path: each pin passes through `SYNC_STAGES` flops; the last stage is `IDR`. `prev` holds `IDR` delayed by one cycle.
  - Rising edge on bit i: `IDR[i] & ~prev[i]`.
  - Falling edge on bit i: `~IDR[i] & prev[i]`.
- Pending set: `ISR[i]` is set when (rise & `RISE[i]`) | (fall & `FALL[i]`). Enable bits are sampled in the same cycle as the edge.
- Edge detection runs in both directions. Output pins read back their driven value, so toggling `ODR` can raise `ISR`.
- Simultaneous W1C and a new edge on the same bit in the same cycle: the set wins, and `ISR[i]` stays 1.
- Disabling `RISE`/`FALL` does not clear `ISR`; it only blocks new sets.

## Timing
- Reset state: all registers are 0, `prev` = 0, `irq` = 0, `ioport` is all high-Z, and `rdata` reflects the zeroed registers.
- Writes take effect on the `clk` edge at which `cs & wr` is sampled. Pin direction and level change in the following cycle.
- Reads are zero-wait; `rdata` is valid in the same cycle as `addr`.
- Pin-to-`IDR` latency is `SYNC_STAGES` edges.
- `ISR` sets one edge after `IDR` changes, i.e. `SYNC_STAGES`+1 edges after the pin changes.
- `irq` follows `ISR` by one further edge, and drops one edge after `ISR` becomes 0.
- Pins held high through reset: `IDR` rises after reset is released, but no pending flag is set because `RISE` is 0 at that point.
- Reset asserted mid-operation: on the next edge all state returns to reset values, regardless of bus activity.

## Test plan
- Reset with `WIDTH`=8: every address reads 0, `ioport` is all Z, and `irq` is 0.
- Write `MODER`=0xFF, then `ODR`=0xA5 → `ioport`=0xA5 on the next cycle. Then write `BSRR`=0x0003_0005 (set bits 0 and 2, clear bits 0 and 1) → `ODR`=0xA5; bit 0 stays set because set wins. Check that a read of `BSRR` returns 0.
- `MODER`=0, external pin 3 driven 0→1 → `IDR[3]`=1 after 2 edges. With `RISE`=0x08, `ISR`=0x08 after 3 edges and `irq`=1 after 4 edges.
- `FALL`=0x01, pin 0 driven 1→0 → `ISR[0]`=1. Write `ISR`=0x01 → `ISR`=0 and `irq` deasserts one edge later. Writing `ISR`=0x00 changes nothing.
- Arrange a rising edge on pin 5 to be detected in the same cycle as a W1C write of `ISR`=0x20 → `ISR[5]` remains 1.
- Assert `reset` for one cycle while pending flags are set and pins are outputs → all registers are 0, `irq`=0 and `ioport` is Z on the next edge.
